serial_pattern_gen: RTL and testbench

- Serial stimulus transmitter: loads a parallel pattern and shifts it out one bit per clock on X. X is the serial input consumed by the team's consecutive-ones Mealy detector.
- Runs a bit-accurate model of that detector alongside the stream. EXP_Y gives the detector output the downstream block must produce for the current bit, and HIT_CNT counts the expected hits.
- Used on-chip as a self-test source and in benches as the driving end of the detector interface.

---
 rtl/serial_pattern_gen_if.sv | 29 ++
 rtl/serial_pattern_gen.sv | 159 +++++++++++++++
 tb/tb_serial_pattern_gen.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_pattern_gen_if.sv
// Bus between the serial pattern generator and whatever drives it: load request,
// pattern and run controls in; serial stream, status and predicted detector output out.
interface serial_pattern_gen_if #(
    parameter int W  = 8,
    parameter int LW = 5,
    parameter int CW = 8
);
    logic          LOAD;
    logic [W-1:0]  DATA;
    logic [LW-1:0] LEN;
    logic          REPEAT;
    logic          STOP;
    logic          X;
    logic          BUSY;
    logic          DONE;
    logic          ERR;
    logic          EXP_Y;
    logic [CW-1:0] HIT_CNT;

    modport master (
        output LOAD, DATA, LEN, REPEAT, STOP,
        input  X, BUSY, DONE, ERR, EXP_Y, HIT_CNT
    );

    modport slave (
        input  LOAD, DATA, LEN, REPEAT, STOP,
        output X, BUSY, DONE, ERR, EXP_Y, HIT_CNT
    );
endinterface

// File: rtl/serial_pattern_gen.sv
// Serial stimulus transmitter for the consecutive-ones detector: shifts a loaded pattern
// out MSB-first on X while tracking the detector's expected output and hit count.
module serial_pattern_gen #(
    parameter int W  = 8,
    parameter int LW = 5,
    parameter int CW = 8
) (
    input logic                 CLK,
    input logic                 RESET,
    serial_pattern_gen_if.slave bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
    typedef enum logic [1:0] {M0, M1, M2} model_t;

    state_t        state_q, state_d;
    model_t        model_q, model_d;
    logic [W-1:0]  pat_q, pat_d;
    logic [LW-1:0] len_q, len_d;
    logic [LW-1:0] bitcnt_q, bitcnt_d;
    logic          rep_q, rep_d;
    logic          stop_q, stop_d;
    logic          x_q, x_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [CW-1:0] hit_q, hit_d;

    logic exp_y;
    logic len_legal;
    logic pass_end;
    logic stop_seen;

    function automatic logic bit_at(input logic [W-1:0] v, input logic [LW-1:0] idx);
        logic [W-1:0] s;
        s = v >> idx;
        return s[0];
    endfunction

    // The detector is Mealy: a hit is reported on the second and later consecutive 1.
    assign exp_y     = x_q && (model_q != M0);
    assign len_legal = (bus.LEN != '0) && (bus.LEN <= LW'(W));
    assign pass_end  = (bitcnt_q == len_q - LW'(1));
    assign stop_seen = stop_q || bus.STOP;

    always_comb begin
        model_d = M0;
        if (x_q) begin
            case (model_q)
                M0:      model_d = M1;
                M1:      model_d = M2;
                M2:      model_d = M1;
                default: model_d = M0;
            endcase
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned, which would infer a latch.
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        rep_d    = rep_q;
        stop_d   = stop_q;
        bitcnt_d = bitcnt_q;
        hit_d    = hit_q;
        x_d      = 1'b0;
        busy_d   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.LOAD) begin
                    if (len_legal) begin
                        pat_d    = bus.DATA;
                        len_d    = bus.LEN;
                        rep_d    = bus.REPEAT;
                        stop_d   = 1'b0;
                        bitcnt_d = '0;
                        hit_d    = '0;
                        x_d      = bit_at(bus.DATA, bus.LEN - LW'(1));
                        busy_d   = 1'b1;
                        state_d  = SHIFT;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            SHIFT: begin
                if (exp_y && (hit_q != '1)) begin
                    hit_d = hit_q + CW'(1);
                end
                stop_d = stop_seen;
                if (!pass_end) begin
                    bitcnt_d = bitcnt_q + LW'(1);
                    x_d      = bit_at(pat_q, len_q - LW'(2) - bitcnt_q);
                    busy_d   = 1'b1;
                end else if (rep_q && !stop_seen) begin
                    // Wrap with no gap; the model keeps running so the stream stays continuous.
                    bitcnt_d = '0;
                    stop_d   = 1'b0;
                    x_d      = bit_at(pat_q, len_q - LW'(1));
                    busy_d   = 1'b1;
                end else begin
                    stop_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = FIN;
                end
            end

            FIN: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q  <= IDLE;
            model_q  <= M0;
            pat_q    <= '0;
            len_q    <= '0;
            bitcnt_q <= '0;
            rep_q    <= 1'b0;
            stop_q   <= 1'b0;
            x_q      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            hit_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            model_q  <= model_d;
            pat_q    <= pat_d;
            len_q    <= len_d;
            bitcnt_q <= bitcnt_d;
            rep_q    <= rep_d;
            stop_q   <= stop_d;
            x_q      <= x_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            hit_q    <= hit_d;
        end
    end

    assign bus.X       = x_q;
    assign bus.BUSY    = busy_q;
    assign bus.DONE    = done_q;
    assign bus.ERR     = err_q;
    assign bus.EXP_Y   = exp_y;
    assign bus.HIT_CNT = hit_q;
endmodule

// File: tb/tb_serial_pattern_gen.sv
// Directed bench for serial_pattern_gen: hand-computed X / EXP_Y sequences, run control,
// illegal lengths and asynchronous reset, sampled on the falling clock edge.
module tb_serial_pattern_gen;
    localparam int W  = 8;
    localparam int LW = 5;
    localparam int CW = 8;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_pattern_gen_if #(.W(W), .LW(LW), .CW(CW)) bus ();

    serial_pattern_gen #(.W(W), .LW(LW), .CW(CW)) dut (
        .CLK   (clk),
        .RESET (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.X, bus.BUSY, bus.DONE, bus.ERR, bus.EXP_Y} !== 5'b0 || bus.HIT_CNT !== 8'd0) begin
            errors++;
            $display("FAIL reset_async: x/busy/done/err/expy=%b%b%b%b%b hit=%0d want all 0",
                     bus.X, bus.BUSY, bus.DONE, bus.ERR, bus.EXP_Y, bus.HIT_CNT);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if ({bus.X, bus.BUSY, bus.DONE, bus.ERR} !== 4'b0 || bus.HIT_CNT !== 8'd0) begin
                errors++;
                $display("FAIL reset_idle cycle %0d: x/busy/done/err=%b%b%b%b hit=%0d want 0000 hit=0",
                         i, bus.X, bus.BUSY, bus.DONE, bus.ERR, bus.HIT_CNT);
            end
        end
    endtask

    task automatic test_basic();
        logic [7:0] exp_x;
        logic [7:0] exp_y;
        exp_x = 8'b0111_0110;
        exp_y = 8'b0011_0010;
        bus.LOAD = 1'b1; bus.DATA = 8'b0111_0110; bus.LEN = 5'd8; bus.REPEAT = 1'b0;
        @(negedge clk);
        bus.LOAD = 1'b0;
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (bus.X !== exp_x[7-i] || bus.BUSY !== 1'b1 || bus.EXP_Y !== exp_y[7-i] || bus.DONE !== 1'b0) begin
                errors++;
                $display("FAIL basic bit %0d: x=%b busy=%b expy=%b done=%b want x=%b busy=1 expy=%b done=0",
                         i, bus.X, bus.BUSY, bus.EXP_Y, bus.DONE, exp_x[7-i], exp_y[7-i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.X !== 1'b0 || bus.HIT_CNT !== 8'd3) begin
            errors++;
            $display("FAIL basic_end: done=%b busy=%b x=%b hit=%0d want done=1 busy=0 x=0 hit=3",
                     bus.DONE, bus.BUSY, bus.X, bus.HIT_CNT);
        end
        @(negedge clk);
        checks++;
        if (bus.DONE !== 1'b0 || bus.HIT_CNT !== 8'd3) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b hit=%0d want done=0 hit=3", bus.DONE, bus.HIT_CNT);
        end
    endtask

    task automatic test_short();
        bus.LOAD = 1'b1; bus.DATA = 8'hFF; bus.LEN = 5'd3; bus.REPEAT = 1'b0;
        @(negedge clk);
        bus.LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.X !== 1'b1 || bus.BUSY !== 1'b1 || bus.EXP_Y !== (i > 0) || bus.ERR !== 1'b0) begin
                errors++;
                $display("FAIL short bit %0d: x=%b busy=%b expy=%b err=%b want x=1 busy=1 expy=%b err=0",
                         i, bus.X, bus.BUSY, bus.EXP_Y, bus.ERR, (i > 0));
            end
            // An illegal LOAD mid-run must be ignored without raising ERR.
            if (i == 1) begin
                bus.LOAD = 1'b1; bus.DATA = 8'h00; bus.LEN = 5'd0;
            end else begin
                bus.LOAD = 1'b0;
            end
            @(negedge clk);
        end
        checks++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.X !== 1'b0 || bus.HIT_CNT !== 8'd2 || bus.ERR !== 1'b0) begin
            errors++;
            $display("FAIL short_end: done=%b busy=%b x=%b hit=%0d err=%b want done=1 busy=0 x=0 hit=2 err=0",
                     bus.DONE, bus.BUSY, bus.X, bus.HIT_CNT, bus.ERR);
        end
        bus.LOAD = 1'b1; bus.DATA = 8'hFF; bus.LEN = 5'd8;
        @(negedge clk);
        bus.LOAD = 1'b0;
        checks++;
        if (bus.BUSY !== 1'b0 || bus.ERR !== 1'b0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL load_in_fin: busy=%b err=%b done=%b want 0 0 0", bus.BUSY, bus.ERR, bus.DONE);
        end
        @(negedge clk);
        checks++;
        if (bus.BUSY !== 1'b0 || bus.X !== 1'b0) begin
            errors++;
            $display("FAIL load_in_fin_idle: busy=%b x=%b want 0 0", bus.BUSY, bus.X);
        end
    endtask

    task automatic test_illegal_len();
        logic [4:0] bad_len [2];
        bad_len[0] = 5'd0;
        bad_len[1] = 5'd9;
        for (int k = 0; k < 2; k++) begin
            bus.LOAD = 1'b1; bus.DATA = 8'hFF; bus.LEN = bad_len[k];
            @(negedge clk);
            bus.LOAD = 1'b0;
            checks++;
            if (bus.ERR !== 1'b1 || bus.BUSY !== 1'b0 || bus.HIT_CNT !== 8'd2 || bus.X !== 1'b0) begin
                errors++;
                $display("FAIL illegal len=%0d: err=%b busy=%b hit=%0d x=%b want err=1 busy=0 hit=2 x=0",
                         bad_len[k], bus.ERR, bus.BUSY, bus.HIT_CNT, bus.X);
            end
            @(negedge clk);
            checks++;
            if (bus.ERR !== 1'b0 || bus.BUSY !== 1'b0) begin
                errors++;
                $display("FAIL illegal_pulse len=%0d: err=%b busy=%b want 0 0", bad_len[k], bus.ERR, bus.BUSY);
            end
        end
    endtask

    task automatic test_repeat_stop();
        // STOP raised together with LOAD must be ignored.
        bus.LOAD = 1'b1; bus.DATA = 8'b0000_0011; bus.LEN = 5'd2; bus.REPEAT = 1'b1; bus.STOP = 1'b1;
        @(negedge clk);
        bus.LOAD = 1'b0; bus.STOP = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (bus.X !== 1'b1 || bus.BUSY !== 1'b1 || bus.EXP_Y !== (i > 0) || bus.DONE !== 1'b0) begin
                errors++;
                $display("FAIL repeat bit %0d: x=%b busy=%b expy=%b done=%b want x=1 busy=1 expy=%b done=0",
                         i, bus.X, bus.BUSY, bus.EXP_Y, bus.DONE, (i > 0));
            end
            bus.STOP = (i == 4);
            @(negedge clk);
        end
        bus.STOP = 1'b0; bus.REPEAT = 1'b0;
        checks++;
        if (bus.DONE !== 1'b1 || bus.BUSY !== 1'b0 || bus.X !== 1'b0 || bus.HIT_CNT !== 8'd5) begin
            errors++;
            $display("FAIL repeat_end: done=%b busy=%b x=%b hit=%0d want done=1 busy=0 x=0 hit=5",
                     bus.DONE, bus.BUSY, bus.X, bus.HIT_CNT);
        end
        @(negedge clk);
        checks++;
        if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL repeat_idle: done=%b busy=%b want 0 0", bus.DONE, bus.BUSY);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [7:0] exp_x;
        exp_x = 8'b0111_0110;
        bus.LOAD = 1'b1; bus.DATA = 8'b0111_0110; bus.LEN = 5'd8; bus.REPEAT = 1'b0;
        @(negedge clk);
        bus.LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.X !== exp_x[7-i]) begin
                errors++;
                $display("FAIL midrst_pre bit %0d: x=%b want %b", i, bus.X, exp_x[7-i]);
            end
            @(negedge clk);
        end
        checks++;
        if (bus.X !== 1'b1 || bus.HIT_CNT !== 8'd1 || bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL midrst_bit4: x=%b hit=%0d busy=%b want x=1 hit=1 busy=1", bus.X, bus.HIT_CNT, bus.BUSY);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.X !== 1'b0 || bus.BUSY !== 1'b0 || bus.HIT_CNT !== 8'd0 || bus.DONE !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: x=%b busy=%b hit=%0d done=%b want all 0",
                     bus.X, bus.BUSY, bus.HIT_CNT, bus.DONE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.DONE !== 1'b0 || bus.BUSY !== 1'b0) begin
                errors++;
                $display("FAIL midrst_nodone cycle %0d: done=%b busy=%b want 0 0", i, bus.DONE, bus.BUSY);
            end
        end
        bus.LOAD = 1'b1; bus.DATA = 8'hFF; bus.LEN = 5'd3;
        @(negedge clk);
        bus.LOAD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (bus.X !== 1'b1 || bus.EXP_Y !== (i > 0) || bus.BUSY !== 1'b1) begin
                errors++;
                $display("FAIL midrst_rerun bit %0d: x=%b expy=%b busy=%b want x=1 expy=%b busy=1",
                         i, bus.X, bus.EXP_Y, bus.BUSY, (i > 0));
            end
            @(negedge clk);
        end
        checks++;
        if (bus.DONE !== 1'b1 || bus.HIT_CNT !== 8'd2) begin
            errors++;
            $display("FAIL midrst_rerun_end: done=%b hit=%0d want done=1 hit=2", bus.DONE, bus.HIT_CNT);
        end
        @(negedge clk);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        bus.LOAD   = 1'b0;
        bus.DATA   = '0;
        bus.LEN    = '0;
        bus.REPEAT = 1'b0;
        bus.STOP   = 1'b0;
        test_reset();
        test_basic();
        test_short();
        test_illegal_len();
        test_repeat_stop();
        test_reset_mid_run();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
